// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one small result FIFO per functional unit, drained
// round-robin onto a registered broadcast port, one entry per cycle.
package cdb_pkg;
  typedef struct packed {
    logic [4:0]  label;
    logic [31:0] data;
  } cdbEntry_t;
endpackage

// Per-source result queue; storage is unreset, only control state resets.
module cdb_queue
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      RST,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  cdbEntry_t wrEntry,
  output logic      ready,
  output logic      nonEmpty,
  output cdbEntry_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  cdbEntry_t mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrEntry;
  end

  // Ready comes from the registered count only, so a full queue popped this
  // cycle still reports not-ready until the next cycle.
  assign ready    = count < CW'(DEPTH);
  assign nonEmpty = count != '0;
  assign head     = mem[rdPtr];
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        Flush,
  input  logic        Src0Valid,
  input  logic [4:0]  Src0Label,
  input  logic [31:0] Src0Data,
  output logic        Src0Ready,
  input  logic        Src1Valid,
  input  logic [4:0]  Src1Label,
  input  logic [31:0] Src1Data,
  output logic        Src1Ready,
  input  logic        Src2Valid,
  input  logic [4:0]  Src2Label,
  input  logic [31:0] Src2Data,
  output logic        Src2Ready,
  output logic        BCEN,
  output logic [4:0]  BClabel,
  output logic [31:0] BCdata
);
  localparam int NUM_SRC = 3;

  logic [NUM_SRC-1:0] srcValid, srcReady, push, pop, nonEmpty;
  cdbEntry_t [NUM_SRC-1:0] srcEntry, head;
  logic [1:0] lastGrant, grantIdx, cand1, cand2;
  logic       grantVld;

  assign srcValid    = {Src2Valid, Src1Valid, Src0Valid};
  assign srcEntry[0] = '{label: Src0Label, data: Src0Data};
  assign srcEntry[1] = '{label: Src1Label, data: Src1Data};
  assign srcEntry[2] = '{label: Src2Label, data: Src2Data};
  assign {Src2Ready, Src1Ready, Src0Ready} = srcReady;

  function automatic logic [1:0] nextSrc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  always_comb begin
    cand1    = nextSrc(lastGrant);
    cand2    = nextSrc(cand1);
    grantVld = |nonEmpty;
    if (nonEmpty[cand1])      grantIdx = cand1;
    else if (nonEmpty[cand2]) grantIdx = cand2;
    else                      grantIdx = lastGrant;
  end

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : gQueue
      // Tag 0 means "no producer" and is dropped at the door.
      assign push[i] = srcValid[i] && srcReady[i] && !Flush && (srcEntry[i].label != '0);
      assign pop[i]  = !Flush && grantVld && (grantIdx == 2'(i));

      cdb_queue #(.DEPTH(DEPTH)) uQueue (
        .clk      (clk),
        .RST      (RST),
        .flush    (Flush),
        .push     (push[i]),
        .pop      (pop[i]),
        .wrEntry  (srcEntry[i]),
        .ready    (srcReady[i]),
        .nonEmpty (nonEmpty[i]),
        .head     (head[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      lastGrant <= 2'd2;
      BCEN      <= 1'b0;
      BClabel   <= '0;
      BCdata    <= '0;
    end else if (Flush) begin
      lastGrant <= 2'd2;
      BCEN      <= 1'b0;
      BClabel   <= '0;
      BCdata    <= '0;
    end else if (grantVld) begin
      lastGrant <= grantIdx;
      BCEN      <= 1'b1;
      BClabel   <= head[grantIdx].label;
      BCdata    <= head[grantIdx].data;
    end else begin
      BCEN      <= 1'b0;
      BClabel   <= '0;
      BCdata    <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        RST, Flush;
  logic        srcV [3];
  logic [4:0]  srcL [3];
  logic [31:0] srcD [3];
  logic        Src0Ready, Src1Ready, Src2Ready;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
  logic [2:0]  dutRdy;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [4:0]  l;
    logic [31:0] d;
  } ent_t;

  ent_t        mq [3][$];
  int          mLast;
  logic        eEn;
  logic [4:0]  eLab;
  logic [31:0] eDat;

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .RST       (RST),
    .Flush     (Flush),
    .Src0Valid (srcV[0]),
    .Src0Label (srcL[0]),
    .Src0Data  (srcD[0]),
    .Src0Ready (Src0Ready),
    .Src1Valid (srcV[1]),
    .Src1Label (srcL[1]),
    .Src1Data  (srcD[1]),
    .Src1Ready (Src1Ready),
    .Src2Valid (srcV[2]),
    .Src2Label (srcL[2]),
    .Src2Data  (srcD[2]),
    .Src2Ready (Src2Ready),
    .BCEN      (BCEN),
    .BClabel   (BClabel),
    .BCdata    (BCdata)
  );

  assign dutRdy = {Src2Ready, Src1Ready, Src0Ready};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] modelRdy();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = mq[i].size() < DEPTH;
    return r;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    mLast = 2;
    eEn   = 1'b0;
    eLab  = '0;
    eDat  = '0;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      srcV[i] = 1'b0;
      srcL[i] = '0;
      srcD[i] = '0;
    end
    Flush = 1'b0;
  endtask

  // One clock: inputs set at the negedge, model advanced at the posedge,
  // returns at the following negedge where outputs are sampled.
  task automatic tick();
    logic [2:0] rdy;
    int g, idx;
    ent_t e;
    rdy = modelRdy();
    @(posedge clk);
    if (Flush) begin
      modelReset();
    end else begin
      g = -1;
      for (int k = 1; k <= 3; k++) begin
        idx = (mLast + k) % 3;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g >= 0) begin
        e     = mq[g].pop_front();
        mLast = g;
        eEn   = 1'b1;
        eLab  = e.l;
        eDat  = e.d;
      end else begin
        eEn  = 1'b0;
        eLab = '0;
        eDat = '0;
      end
      for (int i = 0; i < 3; i++)
        if (srcV[i] && rdy[i] && srcL[i] != 5'd0) mq[i].push_back('{l: srcL[i], d: srcD[i]});
    end
    @(negedge clk);
  endtask

  task automatic pulseReset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    nChecks++;
    if (BCEN !== 1'b0 || BClabel !== 5'd0 || BCdata !== 32'd0) begin
      nFails++;
      $display("FAIL reset_bc: got en=%b lab=%0d dat=%h want 0/0/0", BCEN, BClabel, BCdata);
    end
    nChecks++;
    if (dutRdy !== 3'b111) begin
      nFails++;
      $display("FAIL reset_ready: got %b want 111", dutRdy);
    end
  endtask

  task automatic test_single_push();
    idle();
    srcV[1] = 1'b1; srcL[1] = 5'd5; srcD[1] = 32'hDEADBEEF;
    tick();
    idle();
    nChecks++;
    if (BCEN !== 1'b0) begin
      nFails++;
      $display("FAIL single_nobypass: got en=%b want 0", BCEN);
    end
    tick();
    nChecks++;
    if (BCEN !== 1'b1 || BClabel !== 5'd5 || BCdata !== 32'hDEADBEEF) begin
      nFails++;
      $display("FAIL single_bc: got en=%b lab=%0d dat=%h want 1/5/deadbeef", BCEN, BClabel, BCdata);
    end
    tick();
    nChecks++;
    if (BCEN !== 1'b0) begin
      nFails++;
      $display("FAIL single_once: got en=%b want 0", BCEN);
    end
  endtask

  task automatic test_contention();
    logic [4:0] want;
    pulseReset();
    idle();
    for (int i = 0; i < 3; i++) begin
      srcV[i] = 1'b1; srcL[i] = 5'(i + 1); srcD[i] = 32'(i + 1) * 32'h01010101;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      srcL[i] = 5'(i + 4); srcD[i] = 32'(i + 4) * 32'h01010101;
    end
    tick();
    idle();
    for (int k = 1; k <= 6; k++) begin
      want = 5'(k);
      nChecks++;
      if (BCEN !== 1'b1 || BClabel !== want || BCdata !== 32'(k) * 32'h01010101) begin
        nFails++;
        $display("FAIL contention_%0d: got en=%b lab=%0d dat=%h want 1/%0d", k, BCEN, BClabel, BCdata, want);
      end
      tick();
    end
    nChecks++;
    if (BCEN !== 1'b0) begin
      nFails++;
      $display("FAIL contention_end: got en=%b want 0", BCEN);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] pushed [3][$];
    logic [4:0] seen   [3][$];
    logic [2:0] rdy;
    logic       sawLow;
    int s;
    sawLow = 1'b0;
    idle();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        srcV[i] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
        srcL[i] = 5'(1 + i * 10 + (c % 10));
        srcD[i] = $urandom;
      end
      rdy = modelRdy();
      nChecks++;
      if (dutRdy !== rdy) begin
        nFails++;
        $display("FAIL bp_ready_c%0d: got %b want %b", c, dutRdy, rdy);
      end
      if (!Src0Ready) sawLow = 1'b1;
      for (int i = 0; i < 3; i++) if (srcV[i] && rdy[i]) pushed[i].push_back(srcL[i]);
      tick();
      if (BCEN) begin
        s = (int'(BClabel) - 1) / 10;
        if (BClabel != 0) seen[s].push_back(BClabel);
      end
    end
    idle();
    for (int c = 0; c < 30; c++) begin
      tick();
      if (BCEN) begin
        s = (int'(BClabel) - 1) / 10;
        if (BClabel != 0) seen[s].push_back(BClabel);
      end
    end
    nChecks++;
    if (!sawLow) begin
      nFails++;
      $display("FAIL bp_src0_full: Src0Ready never dropped, want a 0 once count reaches 2");
    end
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (seen[i].size() != pushed[i].size()) begin
        nFails++;
        $display("FAIL bp_count_src%0d: got %0d broadcasts want %0d", i, seen[i].size(), pushed[i].size());
      end else begin
        for (int k = 0; k < pushed[i].size(); k++) begin
          nChecks++;
          if (seen[i][k] !== pushed[i][k]) begin
            nFails++;
            $display("FAIL bp_order_src%0d_%0d: got %0d want %0d", i, k, seen[i][k], pushed[i][k]);
          end
        end
      end
    end
  endtask

  task automatic test_label_zero();
    logic anyBc;
    anyBc = 1'b0;
    idle();
    srcV[2] = 1'b1; srcL[2] = 5'd0; srcD[2] = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      tick();
      anyBc |= BCEN;
    end
    nChecks++;
    if (Src2Ready !== 1'b1) begin
      nFails++;
      $display("FAIL label0_ready: got %b want 1", Src2Ready);
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      tick();
      anyBc |= BCEN;
    end
    nChecks++;
    if (anyBc !== 1'b0) begin
      nFails++;
      $display("FAIL label0_bc: got a broadcast want none");
    end
  endtask

  task automatic fill();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 3; i++) begin
        srcV[i] = 1'b1; srcL[i] = 5'(1 + i * 10 + c); srcD[i] = $urandom;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic anyBc;
    anyBc = 1'b0;
    idle();
    fill();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    for (int i = 0; i < 3; i++) srcV[i] = 1'b0;
    nChecks++;
    if (BCEN !== 1'b0 || BClabel !== 5'd0 || BCdata !== 32'd0 || dutRdy !== 3'b111) begin
      nFails++;
      $display("FAIL flush_state: got en=%b lab=%0d dat=%h rdy=%b want 0/0/0/111", BCEN, BClabel, BCdata, dutRdy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      anyBc |= BCEN;
    end
    nChecks++;
    if (anyBc !== 1'b0) begin
      nFails++;
      $display("FAIL flush_residue: got a broadcast after flush want none");
    end
    // After flush the round-robin pointer restarts so source 0 wins first.
    srcV[2] = 1'b1; srcL[2] = 5'd9; srcD[2] = 32'h9;
    srcV[1] = 1'b1; srcL[1] = 5'd8; srcD[1] = 32'h8;
    srcV[0] = 1'b1; srcL[0] = 5'd7; srcD[0] = 32'h7;
    tick();
    idle();
    tick();
    nChecks++;
    if (BCEN !== 1'b1 || BClabel !== 5'd7) begin
      nFails++;
      $display("FAIL flush_first_grant: got en=%b lab=%0d want 1/7", BCEN, BClabel);
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_async_reset();
    idle();
    fill();
    idle();
    nChecks++;
    if (BCEN !== eEn || BClabel !== eLab) begin
      nFails++;
      $display("FAIL arst_pre: got en=%b lab=%0d want %b/%0d", BCEN, BClabel, eEn, eLab);
    end
    #2;
    RST = 1'b1;
    modelReset();
    #1;
    nChecks++;
    if (BCEN !== 1'b0 || BClabel !== 5'd0 || BCdata !== 32'd0 || dutRdy !== 3'b111) begin
      nFails++;
      $display("FAIL arst_immediate: got en=%b lab=%0d dat=%h rdy=%b want 0/0/0/111", BCEN, BClabel, BCdata, dutRdy);
    end
    @(negedge clk);
    RST = 1'b0;
    srcV[2] = 1'b1; srcL[2] = 5'd20; srcD[2] = 32'h20;
    srcV[1] = 1'b1; srcL[1] = 5'd10; srcD[1] = 32'h10;
    srcV[0] = 1'b1; srcL[0] = 5'd5;  srcD[0] = 32'h5;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++;
      if (BCEN !== 1'b1 || BClabel !== ((k == 0) ? 5'd5 : (k == 1) ? 5'd10 : 5'd20)) begin
        nFails++;
        $display("FAIL arst_order_%0d: got en=%b lab=%0d", k, BCEN, BClabel);
      end
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        srcV[i] = 1'($urandom_range(0, 1));
        srcL[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        srcD[i] = $urandom;
      end
      Flush = ($urandom_range(0, 39) == 0);
      tick();
      nChecks++;
      if (BCEN !== eEn || BClabel !== eLab || BCdata !== eDat) begin
        nFails++;
        $display("FAIL rand_bc_c%0d: got en=%b lab=%0d dat=%h want %b/%0d/%h",
                 c, BCEN, BClabel, BCdata, eEn, eLab, eDat);
      end
      nChecks++;
      if (dutRdy !== modelRdy()) begin
        nFails++;
        $display("FAIL rand_ready_c%0d: got %b want %b", c, dutRdy, modelRdy());
      end
    end
    idle();
  endtask

  initial begin
    RST = 1'b1;
    idle();
    modelReset();
    @(negedge clk);
    test_reset();
    RST = 1'b0;
    test_single_push();
    test_contention();
    test_backpressure();
    test_label_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning entries per source queue (power of two, ≥2).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port Flush  input  1  synchronous clear of all queued results.
REQ-005 The block SHALL have ports SrcNValid  input  1  result valid from FU N, for N = 0 (adder), 1 (multiplier), 2 (load).
REQ-006 The block SHALL have ports SrcNLabel  input  5  reservation-station tag of that result, N = 0..2.
REQ-007 The block SHALL have ports SrcNData  input  32  result value, N = 0..2.
REQ-008 The block SHALL have ports SrcNReady  output  1  queue N can accept a result, N = 0..2.
REQ-009 The block SHALL have port BCEN  output  1  common-data-bus broadcast enable.
REQ-010 The block SHALL have port BClabel  output  5  broadcast tag.
REQ-011 The block SHALL have port BCdata  output  32  broadcast value.

Function
REQ-012 The block SHALL keep one FIFO of DEPTH {label, data} entries per source, with a count of 0..DEPTH and read/write pointers wrapping modulo DEPTH.
REQ-013 SrcNReady SHALL be 1 exactly when countN < DEPTH, decoded from registered count only, with no combinational path from any input.
REQ-014 The block SHALL push on a rising edge when SrcNValid && SrcNReady && !Flush.
REQ-015 A push with SrcNLabel == 0 SHALL be discarded, because tag 0 means "no producer": no enqueue and no count change.
REQ-016 A full queue SHALL report Ready=0 even in a cycle in which it is popped; the freed slot becomes visible the following cycle.
REQ-017 Each cycle with !Flush, the block SHALL select at most one non-empty queue by round-robin, pop its head, and register it onto BCEN=1, BClabel, BCdata at the same edge.
REQ-018 Round-robin SHALL search from (last_grant+1) mod 3 upward and wrap; last_grant SHALL update only on a grant.
REQ-019 When no queue is non-empty, the edge SHALL register BCEN=0, BClabel=0, BCdata=0.
REQ-020 BCEN SHALL be high for exactly one cycle per popped entry, with no holding or repetition.
REQ-021 Latency: a result pushed at edge E into an empty queue with priority SHALL appear on the BC outputs from edge E+1 until edge E+2; there is no bypass from input to BC outputs.
REQ-022 A simultaneous push and pop on the same queue SHALL leave the count unchanged and preserve FIFO order.
REQ-023 Within one source, order SHALL be strict FIFO; across sources, the only ordering guarantee is round-robin.
REQ-024 Flush SHALL, at the edge it is sampled: empty all queues, zero all pointers, set last_grant=2, register BCEN=0 with BClabel=0 and BCdata=0, and ignore all pushes in that cycle.
REQ-025 Flush takes priority over push and pop in the same cycle.
REQ-026 Any label value 1..31 SHALL be passed through unmodified; the block SHALL NOT check tags for duplicates.

Reset
REQ-027 While RST=1, independent of clk, the block SHALL hold: all counts=0, all pointers=0, last_grant=2, BCEN=0, BClabel=0, BCdata=0, and therefore SrcNReady=1 for all N.
REQ-028 Assertion of RST mid-operation SHALL discard all queued entries immediately; after RST deassertion the first grant goes to source 0 if it is non-empty.
REQ-029 FIFO storage contents need no reset; only the control state must reset.

Verification
REQ-030 Single push: Src1 pushes label 5, data 0xDEADBEEF at edge E, queues otherwise empty -> BCEN=1, BClabel=5, BCdata=0xDEADBEEF for one cycle after E+1, then BCEN=0.
REQ-031 Contention: all three sources push together (labels 1, 2, 3) after reset -> broadcasts on three consecutive cycles in order 1, 2, 3; a further simultaneous push of 4, 5, 6 continues in order 4, 5, 6.
REQ-032 Backpressure: Src0 pushes every cycle while Src1 and Src2 are also busy -> Src0Ready drops to 0 once count=2, and no entry is lost or duplicated; the scoreboard matches the sequence of pushed labels to the sequence of broadcast labels.
REQ-033 Label 0: Src2 pushes label 0, data 0x1234 -> no broadcast, Src2 count stays 0.
REQ-034 Flush and reset: with all queues full, Flush=1 for one cycle -> the next cycle shows BCEN=0, all Ready=1 and no later broadcasts; repeating the sequence with an asynchronous RST pulse mid-cycle -> BCEN drops to 0 immediately.
